// File: rtl/burst_link_pkg.sv
// Shared definitions for the burst symbol link (transmitter and future receiver).
//   tx_state_e   : transmitter frame state
//   MIN_SYM_LEN  : shortest symbol the receive-side confidence filter can lock onto
//   frame_cycles : total clk cycles in one frame for a given configuration
package burst_link_pkg;

  localparam int unsigned MIN_SYM_LEN = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  function automatic int unsigned frame_cycles(input int unsigned data_w,
                                               input int unsigned parity_en,
                                               input int unsigned stop_syms,
                                               input int unsigned sym_len);
    return (1 + data_w + parity_en + stop_syms) * sym_len;
  endfunction

endpackage

// File: rtl/sym_timer.sv
// Symbol-period down-counter.
//   clk, reset  : clock, synchronous active-high reset
//   load        : restart a full symbol period (counter := SYM_LEN-1)
//   en          : count this cycle; the counter reloads itself at each symbol end
//   sym_end     : last cycle of the current symbol
//   sym_pre_end : second-to-last cycle of the current symbol
module sym_timer #(
  parameter int unsigned SYM_LEN = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic sym_end,
  output logic sym_pre_end
);

  localparam int unsigned CntW = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SYM_LEN - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CntMax;
    end else if (en) begin
      cnt_q <= (cnt_q == '0) ? CntMax : cnt_q - CntOne;
    end
  end

  assign sym_end     = en && (cnt_q == '0);
  assign sym_pre_end = en && (cnt_q == CntOne);

endmodule

// File: rtl/burst_symbol_tx.sv
// Framed, oversampled serial transmitter for the single-wire comparator link.
// Each word is sent as: start (1), DATA_W data symbols LSB first, optional even
// parity, STOP_SYMS stop symbols (0); every symbol is held SYM_LEN cycles.
//   clk, reset : clock, synchronous active-high reset
//   data_in    : word to send, captured on accept (valid_in && ready_out)
//   valid_in   : data_in is valid
//   ready_out  : idle and able to accept a word
//   tx_out     : registered line output, idles low
//   busy       : registered, high for the whole frame
//   frame_done : registered pulse on the last cycle of the last stop symbol
module burst_symbol_tx
  import burst_link_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned SYM_LEN   = 10,
  parameter int unsigned STOP_SYMS = 1,
  parameter int unsigned PARITY_EN = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              tx_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned BitW  = $clog2(DATA_W + 1);
  localparam int unsigned StopW = $clog2(STOP_SYMS + 1);
  localparam logic [BitW-1:0]  LastBit  = BitW'(DATA_W - 1);
  localparam logic [BitW-1:0]  BitOne   = BitW'(1);
  localparam logic [StopW-1:0] LastStop = StopW'(STOP_SYMS - 1);
  localparam logic [StopW-1:0] StopOne  = StopW'(1);

  if (SYM_LEN < MIN_SYM_LEN || SYM_LEN > 255) begin : g_bad_sym_len
    $error("SYM_LEN must be in 8..255");
  end
  if (STOP_SYMS < 1 || STOP_SYMS > 4) begin : g_bad_stop_syms
    $error("STOP_SYMS must be in 1..4");
  end

  tx_state_e         state_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_next;
  logic              parity_q;
  logic [BitW-1:0]   bit_cnt_q;
  logic [StopW-1:0]  stop_idx_q;
  logic              tx_q;
  logic              busy_q;
  logic              done_q;
  logic              accept;
  logic              sym_end;
  logic              sym_pre_end;

  assign ready_out  = (state_q == StIdle) && !reset;
  assign accept     = valid_in && ready_out;
  assign shift_next = shift_q >> 1;

  sym_timer #(
    .SYM_LEN(SYM_LEN)
  ) u_sym_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .en         (state_q != StIdle),
    .sym_end    (sym_end),
    .sym_pre_end(sym_pre_end)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      bit_cnt_q  <= '0;
      stop_idx_q <= '0;
      tx_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q    <= StStart;
            shift_q    <= data_in;
            parity_q   <= ^data_in;
            bit_cnt_q  <= '0;
            stop_idx_q <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        StStart: begin
          if (sym_end) begin
            state_q <= StData;
            tx_q    <= shift_q[0];
          end
        end
        StData: begin
          if (sym_end) begin
            shift_q   <= shift_next;
            bit_cnt_q <= bit_cnt_q + BitOne;
            if (bit_cnt_q == LastBit) begin
              if (PARITY_EN != 0) begin
                state_q <= StParity;
                tx_q    <= parity_q;
              end else begin
                state_q <= StStop;
                tx_q    <= 1'b0;
              end
            end else begin
              tx_q <= shift_next[0];
            end
          end
        end
        StParity: begin
          if (sym_end) begin
            state_q <= StStop;
            tx_q    <= 1'b0;
          end
        end
        StStop: begin
          // Set one cycle early so the registered pulse lands on the final stop cycle.
          if (sym_pre_end && (stop_idx_q == LastStop)) begin
            done_q <= 1'b1;
          end
          if (sym_end) begin
            if (stop_idx_q == LastStop) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end else begin
              stop_idx_q <= stop_idx_q + StopOne;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_out     = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_burst_symbol_tx.sv
module tb_burst_symbol_tx;
  import burst_link_pkg::*;

  logic       clk = 1'b0;
  logic [2:0] reset;
  logic [2:0] valid_in;
  logic [2:0] ready_out;
  logic [2:0] tx_out;
  logic [2:0] busy;
  logic [2:0] frame_done;
  logic [7:0] data_in [3];

  int tests = 0;
  int fails = 0;

  // Per-cycle trace; index i = i-th negedge after the accept edge.
  bit tr_tx   [0:255];
  bit tr_busy [0:255];
  bit tr_fd   [0:255];
  bit tr_rdy  [0:255];

  always #5 clk = ~clk;

  // dut 0: defaults
  burst_symbol_tx u_dut0 (
    .clk(clk), .reset(reset[0]), .data_in(data_in[0]), .valid_in(valid_in[0]),
    .ready_out(ready_out[0]), .tx_out(tx_out[0]), .busy(busy[0]), .frame_done(frame_done[0])
  );

  // dut 1: parity enabled
  burst_symbol_tx #(.PARITY_EN(1)) u_dut1 (
    .clk(clk), .reset(reset[1]), .data_in(data_in[1]), .valid_in(valid_in[1]),
    .ready_out(ready_out[1]), .tx_out(tx_out[1]), .busy(busy[1]), .frame_done(frame_done[1])
  );

  // dut 2: shortest symbol, two stop symbols
  burst_symbol_tx #(.SYM_LEN(8), .STOP_SYMS(2)) u_dut2 (
    .clk(clk), .reset(reset[2]), .data_in(data_in[2]), .valid_in(valid_in[2]),
    .ready_out(ready_out[2]), .tx_out(tx_out[2]), .busy(busy[2]), .frame_done(frame_done[2])
  );

  task automatic sample(input int d, input int i);
    tr_tx[i]   = tx_out[d];
    tr_busy[i] = busy[d];
    tr_fd[i]   = frame_done[d];
    tr_rdy[i]  = ready_out[d];
  endtask

  // Waits (bounded) for ready, presents one word and returns 1 ns after the accept edge.
  task automatic start_frame(input int d, input logic [7:0] v, input bit keep_valid);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready_out[d] && n < 300) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (ready_out[d] !== 1'b1) begin
      fails++;
      $display("FAIL ready_wait dut%0d ready_out=%b required=1 within 300 cycles", d, ready_out[d]);
    end
    valid_in[d] = 1'b1;
    data_in[d]  = v;
    @(posedge clk);
    #1;
    if (!keep_valid) valid_in[d] = 1'b0;
  endtask

  task automatic capture(input int d, input int n);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      sample(d, i);
    end
  endtask

  // Returns the first cycle in [from,to] whose traced value differs from val, or -1.
  function automatic int first_diff(input int sel, input int from, input int to, input bit val);
    for (int c = from; c <= to; c++) begin
      if ((sel == 0 ? tr_tx[c] : tr_busy[c]) != val) return c;
    end
    return -1;
  endfunction

  function automatic int fd_count(input int n);
    int k;
    k = 0;
    for (int c = 1; c <= n; c++) if (tr_fd[c]) k++;
    return k;
  endfunction

  function automatic int fd_first(input int n);
    for (int c = 1; c <= n; c++) if (tr_fd[c]) return c;
    return -1;
  endfunction

  task automatic test_reset();
    reset    = 3'b111;
    valid_in = 3'b111;
    for (int d = 0; d < 3; d++) data_in[d] = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (ready_out !== 3'b000) begin
      fails++;
      $display("FAIL reset_ready_low ready_out=%b required=000", ready_out);
    end
    tests++;
    if ({tx_out, busy, frame_done} !== 9'd0) begin
      fails++;
      $display("FAIL reset_outputs tx=%b busy=%b fd=%b required=0", tx_out, busy, frame_done);
    end
    // valid_in was high across the reset edges; nothing may have been accepted.
    reset    = 3'b000;
    valid_in = 3'b000;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (ready_out !== 3'b111) begin
      fails++;
      $display("FAIL reset_release_ready ready_out=%b required=111", ready_out);
    end
    tests++;
    if (busy !== 3'b000 || tx_out !== 3'b000) begin
      fails++;
      $display("FAIL reset_wins busy=%b tx=%b required=000/000", busy, tx_out);
    end
  endtask

  task automatic test_basic_a5();
    logic [0:9] exp_sym;
    int bad;
    exp_sym = 10'b1101001010;
    start_frame(0, 8'hA5, 1'b0);
    capture(0, 102);
    for (int s = 0; s < 10; s++) begin
      bad = first_diff(0, 1 + s * 10, 10 + s * 10, exp_sym[s]);
      tests++;
      if (bad >= 0) begin
        fails++;
        $display("FAIL a5_sym%0d tx=%b at cycle %0d required=%b", s, tr_tx[bad], bad, exp_sym[s]);
      end
    end
    bad = first_diff(1, 1, 100, 1'b1);
    tests++;
    if (bad >= 0 || tr_busy[101] !== 1'b0) begin
      fails++;
      $display("FAIL a5_busy bad_cycle=%0d busy101=%b required busy 1..100 then 0", bad,
               tr_busy[101]);
    end
    tests++;
    if (fd_count(102) != 1 || fd_first(102) != 100) begin
      fails++;
      $display("FAIL a5_frame_done pulses=%0d first=%0d required 1 pulse at 100", fd_count(102),
               fd_first(102));
    end
    tests++;
    if (tr_tx[101] !== 1'b0 || tr_rdy[101] !== 1'b1) begin
      fails++;
      $display("FAIL a5_idle tx=%b ready=%b required=0/1", tr_tx[101], tr_rdy[101]);
    end
  endtask

  task automatic test_parity();
    logic [0:10] exp_sym;
    int bad;
    int flen;
    exp_sym = 11'b11110000010;
    flen = int'(frame_cycles(8, 1, 1, 10));
    start_frame(1, 8'h07, 1'b0);
    capture(1, 112);
    for (int s = 0; s < 11; s++) begin
      bad = first_diff(0, 1 + s * 10, 10 + s * 10, exp_sym[s]);
      tests++;
      if (bad >= 0) begin
        fails++;
        $display("FAIL parity_sym%0d tx=%b at cycle %0d required=%b", s, tr_tx[bad], bad,
                 exp_sym[s]);
      end
    end
    tests++;
    if (fd_count(112) != 1 || fd_first(112) != 110 || flen != 110) begin
      fails++;
      $display("FAIL parity_frame_done pulses=%0d first=%0d required 1 pulse at %0d",
               fd_count(112), fd_first(112), flen);
    end
    bad = first_diff(1, 1, 110, 1'b1);
    tests++;
    if (bad >= 0 || tr_busy[111] !== 1'b0) begin
      fails++;
      $display("FAIL parity_busy bad_cycle=%0d busy111=%b required busy 1..110 then 0", bad,
               tr_busy[111]);
    end
  endtask

  task automatic test_back_to_back();
    logic [0:9] exp_a;
    logic [0:9] exp_b;
    int bad;
    exp_a = 10'b1001111000;
    exp_b = 10'b1110000110;
    start_frame(0, 8'h3C, 1'b1);
    data_in[0] = 8'hC3;
    for (int i = 1; i <= 204; i++) begin
      @(negedge clk);
      sample(0, i);
      if (i == 102) valid_in[0] = 1'b0;
    end
    for (int s = 0; s < 9; s++) begin
      bad = first_diff(0, 1 + s * 10, 10 + s * 10, exp_a[s]);
      tests++;
      if (bad >= 0) begin
        fails++;
        $display("FAIL b2b_first_sym%0d tx=%b at cycle %0d required=%b", s, tr_tx[bad], bad,
                 exp_a[s]);
      end
    end
    bad = first_diff(0, 91, 101, 1'b0);
    tests++;
    if (bad >= 0 || tr_tx[102] !== 1'b1) begin
      fails++;
      $display("FAIL b2b_gap bad_cycle=%0d tx102=%b required low 91..101 then high at 102", bad,
               tr_tx[102]);
    end
    tests++;
    if (tr_busy[101] !== 1'b0 || tr_rdy[101] !== 1'b1 || tr_busy[102] !== 1'b1) begin
      fails++;
      $display("FAIL b2b_idle_cycle busy101=%b ready101=%b busy102=%b required=0/1/1",
               tr_busy[101], tr_rdy[101], tr_busy[102]);
    end
    for (int s = 0; s < 10; s++) begin
      bad = first_diff(0, 102 + s * 10, 111 + s * 10, exp_b[s]);
      tests++;
      if (bad >= 0) begin
        fails++;
        $display("FAIL b2b_second_sym%0d tx=%b at cycle %0d required=%b", s, tr_tx[bad], bad,
                 exp_b[s]);
      end
    end
    tests++;
    if (fd_count(204) != 2 || !tr_fd[100] || !tr_fd[201]) begin
      fails++;
      $display("FAIL b2b_frame_done pulses=%0d fd100=%b fd201=%b required 2 pulses at 100,201",
               fd_count(204), tr_fd[100], tr_fd[201]);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [0:9] exp_sym;
    int bad;
    int fd_seen;
    int tx_seen;
    exp_sym = 10'b1100000000;
    start_frame(0, 8'hFF, 1'b0);
    capture(0, 37);
    bad = first_diff(0, 1, 37, 1'b1);
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL midrst_pre tx=%b at cycle %0d required=1", tr_tx[bad], bad);
    end
    reset[0] = 1'b1;
    @(posedge clk);
    #1;
    reset[0] = 1'b0;
    @(negedge clk);
    tests++;
    if (tx_out[0] !== 1'b0 || busy[0] !== 1'b0 || ready_out[0] !== 1'b1) begin
      fails++;
      $display("FAIL midrst_after tx=%b busy=%b ready=%b required=0/0/1", tx_out[0], busy[0],
               ready_out[0]);
    end
    fd_seen = 0;
    tx_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (frame_done[0]) fd_seen++;
      if (tx_out[0]) tx_seen++;
      @(negedge clk);
    end
    tests++;
    if (fd_seen != 0 || tx_seen != 0) begin
      fails++;
      $display("FAIL midrst_quiet frame_done_cycles=%0d tx_high_cycles=%0d required=0/0",
               fd_seen, tx_seen);
    end
    start_frame(0, 8'h01, 1'b0);
    capture(0, 102);
    for (int s = 0; s < 10; s++) begin
      bad = first_diff(0, 1 + s * 10, 10 + s * 10, exp_sym[s]);
      tests++;
      if (bad >= 0) begin
        fails++;
        $display("FAIL midrst_new_sym%0d tx=%b at cycle %0d required=%b", s, tr_tx[bad], bad,
                 exp_sym[s]);
      end
    end
    tests++;
    if (fd_count(102) != 1 || fd_first(102) != 100) begin
      fails++;
      $display("FAIL midrst_new_done pulses=%0d first=%0d required 1 pulse at 100",
               fd_count(102), fd_first(102));
    end
  endtask

  task automatic test_data_change();
    logic [0:9] exp_sym;
    int bad;
    exp_sym = 10'b1010110100;
    start_frame(0, 8'h5A, 1'b0);
    for (int i = 1; i <= 102; i++) begin
      @(negedge clk);
      sample(0, i);
      if (i >= 2 && i <= 90) begin
        data_in[0]  = 8'($urandom);
        valid_in[0] = 1'b1;
      end else begin
        valid_in[0] = 1'b0;
      end
    end
    for (int s = 0; s < 10; s++) begin
      bad = first_diff(0, 1 + s * 10, 10 + s * 10, exp_sym[s]);
      tests++;
      if (bad >= 0) begin
        fails++;
        $display("FAIL hold_sym%0d tx=%b at cycle %0d required=%b", s, tr_tx[bad], bad,
                 exp_sym[s]);
      end
    end
    tests++;
    if (fd_count(102) != 1 || fd_first(102) != 100 || tr_busy[101] !== 1'b0) begin
      fails++;
      $display("FAIL hold_done pulses=%0d first=%0d busy101=%b required 1 at 100, busy 0",
               fd_count(102), fd_first(102), tr_busy[101]);
    end
  endtask

  task automatic test_short_symbols();
    int bad;
    int flen;
    flen = int'(frame_cycles(8, 0, 2, 8));
    start_frame(2, 8'h00, 1'b0);
    capture(2, 92);
    bad = first_diff(0, 1, 8, 1'b1);
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL sym8_start tx=%b at cycle %0d required=1", tr_tx[bad], bad);
    end
    bad = first_diff(0, 9, 92, 1'b0);
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL sym8_low tx=%b at cycle %0d required=0", tr_tx[bad], bad);
    end
    tests++;
    if (fd_count(92) != 1 || fd_first(92) != 88 || flen != 88) begin
      fails++;
      $display("FAIL sym8_done pulses=%0d first=%0d required 1 pulse at %0d", fd_count(92),
               fd_first(92), flen);
    end
    bad = first_diff(1, 1, 88, 1'b1);
    tests++;
    if (bad >= 0 || tr_busy[89] !== 1'b0) begin
      fails++;
      $display("FAIL sym8_busy bad_cycle=%0d busy89=%b required busy 1..88 then 0", bad,
               tr_busy[89]);
    end
  endtask

  initial begin
    reset    = 3'b111;
    valid_in = 3'b000;
    for (int d = 0; d < 3; d++) data_in[d] = 8'h00;
    test_reset();
    test_basic_a5();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_data_change();
    test_short_symbols();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation exceeded time limit, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
